// File: rtl/rif_reg_pkg.sv
// Shared definitions for the rif register bank: register indices, access
// types, reset values and the byte-strobe expansion helper.
package rif_reg_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_IRQ_RAW  = 3'd2;
    localparam logic [2:0] REG_IRQ_MASK = 3'd3;
    localparam logic [2:0] REG_IRQ_STAT = 3'd4;
    localparam logic [2:0] REG_SCRATCH  = 3'd5;
    localparam logic [2:0] REG_COUNTER  = 3'd6;
    localparam logic [2:0] REG_ID       = 3'd7;

    typedef enum logic [1:0] {
        RW  = 2'd0,
        RO  = 2'd1,
        W1C = 2'd2
    } access_e;

    localparam access_e REG_ACCESS [8] = '{RW, RO, W1C, RW, RO, RW, RW, RO};

    localparam logic [63:0] REG_RESET [8] = '{default: 64'd0};

    // Widest supported register is 64 bits, so strobes are at most 8 bits.
    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = 64'd0;
        for (int b = 0; b < 8; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rif_strb_reg.sv
// Byte-strobed register with a parameterised reset value.
module rif_strb_reg
    import rif_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    BYTE_COUNT  = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  wr_en,
    input  logic [BYTE_COUNT-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mask_s;
    logic [DATA_WIDTH-1:0] q_r;

    assign mask_s = DATA_WIDTH'(strb_to_mask(8'(wstrb)));
    assign q      = q_r;

    // Merge strobed bytes of wdata into the held value.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            q_r <= RESET_VALUE;
        end else if (wr_en) begin
            q_r <= (q_r & ~mask_s) | (wdata & mask_s);
        end else begin
            q_r <= q_r;
        end
    end

endmodule

// File: rtl/rif_reg_bank.sv
// Eight-register bank behind the AHB-Lite adapter: combinational decode and
// read data, byte-strobed writes, W1C interrupt latch and a registered irq.
module rif_reg_bank
    import rif_reg_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter int          BYTE_COUNT = DATA_WIDTH / 8,
    parameter logic [31:0] ID_VALUE   = 32'h0000_A001
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] rif_addr,
    input  logic                  rif_wr_req,
    input  logic                  rif_rd_req,
    input  logic [BYTE_COUNT-1:0] rif_wstrb,
    input  logic [DATA_WIDTH-1:0] rif_wdata,
    output logic                  rif_wvalid,
    output logic                  rif_rvalid,
    output logic [DATA_WIDTH-1:0] rif_rdata,
    input  logic [DATA_WIDTH-1:0] hw_status,
    input  logic [DATA_WIDTH-1:0] hw_event,
    input  logic                  hw_tick,
    output logic [DATA_WIDTH-1:0] ctrl_o,
    output logic                  irq
);

    localparam int                    LSB_W = $clog2(BYTE_COUNT);
    localparam logic [DATA_WIDTH-1:0] ID_S  = DATA_WIDTH'(ID_VALUE);
    localparam logic [DATA_WIDTH-1:0] ONE_S = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic                  aligned_s;
    logic                  in_range_s;
    logic [2:0]            reg_idx_s;
    logic                  wvalid_s;
    logic                  rvalid_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic [DATA_WIDTH-1:0] strb_mask_s;
    logic [DATA_WIDTH-1:0] ctrl_s;
    logic [DATA_WIDTH-1:0] mask_s;
    logic [DATA_WIDTH-1:0] scratch_s;
    logic [DATA_WIDTH-1:0] raw_next_s;
    logic [DATA_WIDTH-1:0] cnt_next_s;
    logic [DATA_WIDTH-1:0] raw_r;
    logic [DATA_WIDTH-1:0] cnt_r;
    logic                  irq_r;

    generate
        if (LSB_W == 0) begin : g_byte_regs
            assign aligned_s = 1'b1;
        end else begin : g_wide_regs
            assign aligned_s = (rif_addr[LSB_W-1:0] == {LSB_W{1'b0}});
        end
    endgenerate

    assign in_range_s  = (rif_addr[ADDR_WIDTH-1:LSB_W+3] == {(ADDR_WIDTH-LSB_W-3){1'b0}});
    assign reg_idx_s   = rif_addr[LSB_W+2:LSB_W];
    assign rvalid_s    = rif_rd_req && in_range_s && aligned_s;
    assign wvalid_s    = rif_wr_req && in_range_s && aligned_s && (REG_ACCESS[reg_idx_s] != RO);
    assign strb_mask_s = DATA_WIDTH'(strb_to_mask(8'(rif_wstrb)));

    rif_strb_reg #(.DATA_WIDTH(DATA_WIDTH), .BYTE_COUNT(BYTE_COUNT),
                   .RESET_VALUE(DATA_WIDTH'(REG_RESET[REG_CTRL]))) u_ctrl (
        .HCLK(HCLK), .HRESETn(HRESETn), .wr_en(wvalid_s && (reg_idx_s == REG_CTRL)),
        .wstrb(rif_wstrb), .wdata(rif_wdata), .q(ctrl_s));

    rif_strb_reg #(.DATA_WIDTH(DATA_WIDTH), .BYTE_COUNT(BYTE_COUNT),
                   .RESET_VALUE(DATA_WIDTH'(REG_RESET[REG_IRQ_MASK]))) u_irq_mask (
        .HCLK(HCLK), .HRESETn(HRESETn), .wr_en(wvalid_s && (reg_idx_s == REG_IRQ_MASK)),
        .wstrb(rif_wstrb), .wdata(rif_wdata), .q(mask_s));

    rif_strb_reg #(.DATA_WIDTH(DATA_WIDTH), .BYTE_COUNT(BYTE_COUNT),
                   .RESET_VALUE(DATA_WIDTH'(REG_RESET[REG_SCRATCH]))) u_scratch (
        .HCLK(HCLK), .HRESETn(HRESETn), .wr_en(wvalid_s && (reg_idx_s == REG_SCRATCH)),
        .wstrb(rif_wstrb), .wdata(rif_wdata), .q(scratch_s));

    // Next-state for IRQ_RAW (events beat clears) and COUNTER (writes beat ticks).
    always_comb begin
        raw_next_s = raw_r | hw_event;
        cnt_next_s = cnt_r;
        if (wvalid_s && (reg_idx_s == REG_IRQ_RAW)) begin
            raw_next_s = (raw_r & ~(rif_wdata & strb_mask_s)) | hw_event;
        end else begin
            raw_next_s = raw_r | hw_event;
        end
        if (wvalid_s && (reg_idx_s == REG_COUNTER)) begin
            cnt_next_s = (cnt_r & ~strb_mask_s) | (rif_wdata & strb_mask_s);
        end else if (hw_tick) begin
            cnt_next_s = cnt_r + ONE_S;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State held at top level: interrupt latch, counter, irq output.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            raw_r <= DATA_WIDTH'(REG_RESET[REG_IRQ_RAW]);
            cnt_r <= DATA_WIDTH'(REG_RESET[REG_COUNTER]);
            irq_r <= 1'b0;
        end else begin
            raw_r <= raw_next_s;
            cnt_r <= cnt_next_s;
            irq_r <= |(raw_r & mask_s);
        end
    end

    // Read mux; returns pre-write values, zero when the read is not accepted.
    always_comb begin
        rdata_s = {DATA_WIDTH{1'b0}};
        if (rvalid_s) begin
            case (reg_idx_s)
                REG_CTRL:     rdata_s = ctrl_s;
                REG_STATUS:   rdata_s = hw_status;
                REG_IRQ_RAW:  rdata_s = raw_r;
                REG_IRQ_MASK: rdata_s = mask_s;
                REG_IRQ_STAT: rdata_s = raw_r & mask_s;
                REG_SCRATCH:  rdata_s = scratch_s;
                REG_COUNTER:  rdata_s = cnt_r;
                REG_ID:       rdata_s = ID_S;
                default:      rdata_s = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            rdata_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign rif_wvalid = wvalid_s;
    assign rif_rvalid = rvalid_s;
    assign rif_rdata  = rdata_s;
    assign ctrl_o     = ctrl_s;
    assign irq        = irq_r;

endmodule

// File: tb/tb_rif_reg_bank.sv
// Randomised self-checking bench for rif_reg_bank against a behavioural
// register-map model.
module tb_rif_reg_bank;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [11:0] rif_addr = 12'd0;
    logic        rif_wr_req = 1'b0;
    logic        rif_rd_req = 1'b0;
    logic [3:0]  rif_wstrb = 4'd0;
    logic [31:0] rif_wdata = 32'd0;
    logic        rif_wvalid;
    logic        rif_rvalid;
    logic [31:0] rif_rdata;
    logic [31:0] hw_status = 32'd0;
    logic [31:0] hw_event = 32'd0;
    logic        hw_tick = 1'b0;
    logic [31:0] ctrl_o;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_ctrl, m_raw, m_mask, m_scratch, m_cnt;
    logic        m_irq;

    rif_reg_bank dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .rif_addr(rif_addr),
        .rif_wr_req(rif_wr_req), .rif_rd_req(rif_rd_req), .rif_wstrb(rif_wstrb),
        .rif_wdata(rif_wdata), .rif_wvalid(rif_wvalid), .rif_rvalid(rif_rvalid),
        .rif_rdata(rif_rdata), .hw_status(hw_status), .hw_event(hw_event),
        .hw_tick(hw_tick), .ctrl_o(ctrl_o), .irq(irq));

    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = 32'd0; m_raw = 32'd0; m_mask = 32'd0;
        m_scratch = 32'd0; m_cnt = 32'd0; m_irq = 1'b0;
    endfunction

    function automatic logic model_aligned(input logic [11:0] addr);
        return (addr % 12'd4) == 12'd0;
    endfunction

    function automatic logic model_wvalid(input logic [11:0] addr, input logic wr);
        int idx;
        idx = int'(addr) / 4;
        return wr && model_aligned(addr) && (idx == 0 || idx == 2 || idx == 3 || idx == 5 || idx == 6);
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] addr, input logic rd,
                                               input logic [31:0] status);
        int idx;
        idx = int'(addr) / 4;
        if (!rd || !model_aligned(addr) || idx > 7) return 32'd0;
        case (idx)
            0: return m_ctrl;
            1: return status;
            2: return m_raw;
            3: return m_mask;
            4: return m_raw & m_mask;
            5: return m_scratch;
            6: return m_cnt;
            7: return 32'h0000_A001;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(input logic [11:0] addr, input logic wr,
                                       input logic [3:0] strb, input logic [31:0] wdata,
                                       input logic [31:0] ev, input logic tick);
        logic [31:0] bm;
        logic [31:0] merged;
        logic        wv;
        int          idx;
        for (int b = 0; b < 4; b++) bm[b*8 +: 8] = strb[b] ? 8'hFF : 8'h00;
        idx = int'(addr) / 4;
        wv  = model_wvalid(addr, wr);
        m_irq = ((m_raw & m_mask) != 32'd0);
        if (wv && idx == 2) m_raw = m_raw & ~(wdata & bm);
        m_raw = m_raw | ev;
        if (wv && idx == 6) m_cnt = (m_cnt & ~bm) | (wdata & bm);
        else if (tick) m_cnt = m_cnt + 32'd1;
        if (wv && idx == 0) m_ctrl = (m_ctrl & ~bm) | (wdata & bm);
        if (wv && idx == 3) m_mask = (m_mask & ~bm) | (wdata & bm);
        if (wv && idx == 5) m_scratch = (m_scratch & ~bm) | (wdata & bm);
    endfunction

    // One request cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic cycle(input logic [11:0] addr, input logic wr, input logic rd,
                         input logic [3:0] strb, input logic [31:0] wdata,
                         input logic [31:0] ev, input logic tick, output logic [31:0] rd_obs);
        @(negedge HCLK);
        rif_addr = addr; rif_wr_req = wr; rif_rd_req = rd; rif_wstrb = strb;
        rif_wdata = wdata; hw_event = ev; hw_tick = tick; hw_status = $urandom;
        #1;
        check_eq("rvalid", 64'(rif_rvalid), 64'(rd && model_aligned(addr) && (int'(addr) / 4) <= 7));
        check_eq("wvalid", 64'(rif_wvalid), 64'(model_wvalid(addr, wr)));
        check_eq("rdata", 64'(rif_rdata), 64'(model_read(addr, rd, hw_status)));
        rd_obs = rif_rdata;
        @(posedge HCLK);
        model_step(addr, wr, strb, wdata, ev, tick);
        #1;
        check_eq("ctrl_o", 64'(ctrl_o), 64'(m_ctrl));
        check_eq("irq", 64'(irq), 64'(m_irq));
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] v);
        cycle(addr, 1'b0, 1'b1, 4'h0, 32'd0, 32'd0, 1'b0, v);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [3:0] strb, input logic [31:0] d,
                      input logic [31:0] ev, input logic tick);
        logic [31:0] v;
        cycle(addr, 1'b1, 1'b0, strb, d, ev, tick, v);
    endtask

    initial begin
        logic [31:0] v;
        model_reset();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int i = 0; i < 8; i++) rd(12'(i * 4), v);
        rd(12'h01C, v);
        check_eq("id_const", 64'(v), 64'h0000_A001);

        wr(12'h000, 4'b0101, 32'hDEADBEEF, 32'd0, 1'b0);
        rd(12'h000, v);
        check_eq("ctrl_strb", 64'(v), 64'h00AD00EF);
        check_eq("ctrl_o_strb", 64'(ctrl_o), 64'h00AD00EF);
        wr(12'h01C, 4'hF, 32'h1234_5678, 32'd0, 1'b0);
        rd(12'h01C, v);
        check_eq("id_after_wr", 64'(v), 64'h0000_A001);

        wr(12'h00C, 4'hF, 32'h4, 32'h5, 1'b0);
        rd(12'h010, v);
        check_eq("irq_stat", 64'(v), 64'h4);
        check_eq("irq_set", 64'(irq), 64'd1);
        wr(12'h008, 4'hF, 32'h4, 32'h4, 1'b0);
        rd(12'h008, v);
        check_eq("raw_keep", 64'(v), 64'h5);
        wr(12'h008, 4'hF, 32'h4, 32'd0, 1'b0);
        rd(12'h008, v);
        check_eq("raw_clr", 64'(v), 64'h1);
        check_eq("irq_clr", 64'(irq), 64'd0);

        wr(12'h018, 4'hF, 32'hFFFF_FFFE, 32'd0, 1'b0);
        repeat (2) cycle(12'h000, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, v);
        rd(12'h018, v);
        check_eq("cnt_wrap", 64'(v), 64'd0);
        cycle(12'h000, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, v);
        rd(12'h018, v);
        check_eq("cnt_one", 64'(v), 64'd1);
        wr(12'h018, 4'hF, 32'h10, 32'd0, 1'b1);
        rd(12'h018, v);
        check_eq("cnt_wr_prio", 64'(v), 64'h10);

        rd(12'h020, v);
        rd(12'h002, v);
        wr(12'h010, 4'hF, 32'hFFFF_FFFF, 32'd0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic [11:0] a;
            logic [31:0] ev;
            a  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 63))
                                             : 12'($urandom_range(0, 8) * 4);
            ev = ($urandom_range(0, 7) == 0) ? (32'($urandom) & 32'h0000_00FF) : 32'd0;
            cycle(a, 1'($urandom), 1'($urandom), 4'($urandom), 32'($urandom), ev,
                  1'($urandom), v);
        end

        wr(12'h00C, 4'hF, 32'hFFFF_FFFF, 32'hFF, 1'b0);
        @(negedge HCLK);
        rif_addr = 12'h000; rif_wr_req = 1'b1; rif_rd_req = 1'b1; rif_wstrb = 4'hF;
        rif_wdata = 32'hCAFE_F00D; hw_event = 32'hFF; hw_tick = 1'b1;
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        check_eq("rst_ctrl_o", 64'(ctrl_o), 64'd0);
        check_eq("rst_irq", 64'(irq), 64'd0);
        check_eq("rst_rdata", 64'(rif_rdata), 64'd0);
        @(posedge HCLK);
        @(negedge HCLK);
        rif_wr_req = 1'b0; rif_rd_req = 1'b0; hw_event = 32'd0; hw_tick = 1'b0;
        HRESETn = 1'b1;
        for (int i = 0; i < 8; i++) rd(12'(i * 4), v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rif_reg_bank.md
# rif_reg_bank

Register bank on the register-interface (rif) side of the AHB-Lite adapter. It consumes `rif_*` requests and returns data plus a same-cycle valid/error indication. It holds a fixed map of 8 word registers: control, status, interrupt raw/mask/status, scratch, event counter and ID. It also drives a registered interrupt line to the system.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: rif address width, in bytes.
- `DATA_WIDTH`, 32: register width; one of 8/16/32/64.
- `BYTE_COUNT`, DATA_WIDTH/8: number of strobe bits.
- `ID_VALUE`, 32'h0000_A001: constant returned by the ID register, truncated to DATA_WIDTH.

Ports:
- `HCLK`  in  1  clock.
- `HRESETn`  in  1  reset; asynchronous, active-low.
- `rif_addr`  in  ADDR_WIDTH  byte address.
- `rif_wr_req`  in  1  write request, level; acted on every cycle it is high.
- `rif_rd_req`  in  1  read request, level.
- `rif_wstrb`  in  BYTE_COUNT  byte enables.
- `rif_wdata`  in  DATA_WIDTH  write data.
- `rif_wvalid`  out  1  combinational; write accepted.
- `rif_rvalid`  out  1  combinational; read accepted.
- `rif_rdata`  out  DATA_WIDTH  combinational read data.
- `hw_status`  in  DATA_WIDTH  live status, sampled combinationally on read.
- `hw_event`  in  DATA_WIDTH  per-bit event pulses into IRQ_RAW.
- `hw_tick`  in  1  counter increment enable.
- `ctrl_o`  out  DATA_WIDTH  CTRL register value.
- `irq`  out  1  registered `|(IRQ_RAW & IRQ_MASK)`.

## Operation
- Word index is `rif_addr[ADDR_WIDTH-1:log2(BYTE_COUNT)]`.
- An address is misaligned when `rif_addr[log2(BYTE_COUNT)-1:0] != 0`.
- Register map (index, name, access, reset):
  - 0 CTRL, RW, 0.
  - 1 STATUS, RO, reads `hw_status`.
  - 2 IRQ_RAW, W1C, 0.
  - 3 IRQ_MASK, RW, 0.
  - 4 IRQ_STAT, RO, reads RAW & MASK.
  - 5 SCRATCH, RW, 0.
  - 6 COUNTER, RW, 0.
  - 7 ID, RO, reads ID_VALUE.
- `rif_rvalid` = `rif_rd_req` && index ≤ 7 && aligned.
  - When `rif_rvalid`=0, `rif_rdata` = 0.
  - `rif_rdata` is also 0 when `rif_rd_req`=0.
- `rif_wvalid` = `rif_wr_req` && index ∈ {0,2,3,5,6} && aligned.
  - Writes to RO registers, out-of-range indices or misaligned addresses give `rif_wvalid`=0 and have no state change. The adapter turns this into HRESP ERROR.
- RW registers (CTRL, IRQ_MASK, SCRATCH, COUNTER) update each byte whose `rif_wstrb` bit is set. All other bytes hold.
- IRQ_RAW:
  - next = (RAW & ~(wdata & strb_mask)) | hw_event.
  - A set from `hw_event` wins over a clear in the same cycle.
- COUNTER:
  - +1 per cycle with `hw_tick`=1; wraps from all-ones to 0.
  - A valid write takes priority over the increment in the same cycle. Written bytes take the new value; unwritten bytes hold; no increment that cycle.
- Reads have no side effects.
- `rif_wr_req` and `rif_rd_req` both high in one cycle: the write and the read are each decoded independently. The read returns the pre-write value.

## Timing
- Decode, valid and read data are combinational, with zero-cycle latency. This is required because the adapter samples the valid signals in the same cycle as the request.
- Register state updates on the HCLK edge that ends the request cycle.
- `irq` is registered: it asserts one cycle after RAW&MASK becomes nonzero and deasserts one cycle after it clears.
- Reset values:
  - All registers 0.
  - `irq`=0.
  - `ctrl_o`=0.
  - Combinational outputs are 0 while requests are low.
- Reset asserted mid-request clears all state immediately, including any event captured in that cycle.

## Structure
- Package `rif_reg_pkg`:
  - Register index constants `REG_CTRL` … `REG_ID`.
  - Access-type enum {RW, RO, W1C}.
  - Per-index access table and reset values.
  - `strb_to_mask(strb)` function, which expands byte strobes to a bit mask.
- Sub-module `rif_strb_reg`: a byte-strobed DATA_WIDTH register with reset value. It is instantiated for CTRL, IRQ_MASK and SCRATCH. COUNTER and IRQ_RAW are coded in the top level.

## Test plan
- Reset, then read indices 0–7:
  - ID returns 0x0000_A001.
  - STATUS returns `hw_status`.
  - All others return 0, each with `rif_rvalid`=1.
- Write CTRL=0xDEADBEEF with strb=4'b0101, then read back:
  - Readback = 0x00AD00EF and `ctrl_o` matches.
  - A write to ID gives `rif_wvalid`=0 and ID is unchanged.
- IRQ sequence:
  1. Pulse `hw_event`=0x5 and set MASK=0x4: `irq`=1 next cycle and IRQ_STAT=0x4.
  2. W1C write 0x4 in the same cycle as a new `hw_event` bit 2: RAW keeps bit 2.
  3. Clear bit 2 with no event: RAW=0x1 and `irq`=0 one cycle later.
- Load COUNTER=0xFFFF_FFFE, then hold `hw_tick` high for 3 cycles: reads 0 after 2 ticks and 1 after 3. A write during a tick loads the value with no +1.
- Error decode, each with valid=0 and rdata=0:
  - Read at address 0x020 (index 8).
  - Read at 0x002 (misaligned).
  - Write at 0x010 (IRQ_STAT).
- Assert HRESETn low during a CTRL write with `hw_event` active: all registers and `irq` are 0 immediately.
